alu_arbiter: RTL and testbench

Sequencing and arbitration controller sharing the single combinational 8-bit ALU between two requesters (port 0, port 1). It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands. It captures the result and holds it on the owning port's response channel until that requester accepts it. It also generates its own zero and error flags from the captured result and opcode.

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter sequencing a shared external 8-bit ALU
module alu_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [2:0] req_op0,
  input  logic [2:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_b1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [2:0] alu_instruction,
  output logic [7:0] alu_input1,
  output logic [7:0] alu_input2,
  input  logic [7:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, next_state;
  logic       owner;
  logic       last_grant;
  logic       winner;
  logic       accept;
  logic [2:0] op_r;
  logic [7:0] a_r, b_r;

  // With both ports valid, round-robin hands the grant to the port that did not win last.
  always_comb begin
    winner = 1'b0;
    if (PRIORITY_MODE != 0) begin
      winner = ~req_valid[0];
    end else if (&req_valid) begin
      winner = ~last_grant;
    end else begin
      winner = req_valid[1];
    end
  end

  assign accept = (state == IDLE) && (|req_valid);

  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          // Gated by reset_n so the ready strobe drops the instant reset is applied.
          req_ready[winner] = reset_n;
          next_state        = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_r       <= 3'd0;
      a_r        <= 8'd0;
      b_r        <= 8'd0;
      rsp_result <= 8'd0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        owner      <= winner;
        last_grant <= winner;
        op_r       <= winner ? req_op1 : req_op0;
        a_r        <= winner ? req_a1  : req_a0;
        b_r        <= winner ? req_b1  : req_b0;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= (alu_result == 8'h00);
        rsp_err    <= (op_r > 3'b100);
      end
    end
  end

  assign alu_instruction = op_r;
  assign alu_input1      = a_r;
  assign alu_input2      = b_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter in both arbitration modes
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [2:0] req_op0 = 3'd0, req_op1 = 3'd0;
  logic [7:0] req_a0 = 8'd0, req_a1 = 8'd0, req_b0 = 8'd0, req_b1 = 8'd0;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [7:0] rsp_result;
  logic       rsp_zero, rsp_err;
  logic [2:0] alu_instruction;
  logic [7:0] alu_input1, alu_input2, alu_result;

  logic [1:0] f_req_valid = 2'b00;
  logic [1:0] f_req_ready;
  logic [1:0] f_rsp_valid;
  logic [1:0] f_rsp_ready = 2'b00;
  logic [7:0] f_rsp_result;
  logic       f_rsp_zero, f_rsp_err;
  logic [2:0] f_alu_instruction;
  logic [7:0] f_alu_input1, f_alu_input2, f_alu_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] rot;
    rot = {a, a} << b[2:0];
    case (op)
      3'd0:    return a ^ b;
      3'd1:    return (a == b) ? 8'h00 : 8'h01;
      3'd2:    return a + b;
      3'd3:    return a & b;
      3'd4:    return rot[15:8];
      default: return 8'hFF;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_instruction, alu_input1, alu_input2);
  assign f_alu_result = alu_f(f_alu_instruction, f_alu_input1, f_alu_input2);

  alu_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_instruction(alu_instruction), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_result(alu_result)
  );

  alu_arbiter #(.PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_op0(3'd2), .req_op1(3'd0),
    .req_a0(8'hF0), .req_a1(8'h5A), .req_b0(8'h20), .req_b1(8'h5A),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err),
    .alu_instruction(f_alu_instruction), .alu_input1(f_alu_input1), .alu_input2(f_alu_input2),
    .alu_result(f_alu_result)
  );

  typedef struct {
    logic       port;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       e;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    logic [1:0] oh;
    int n;
    oh = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    if (v.port) begin
      req_op1 = v.op; req_a1 = v.a; req_b1 = v.b;
    end else begin
      req_op0 = v.op; req_a0 = v.a; req_b0 = v.b;
    end
    req_valid = oh;
    #1;
    n = 0;
    while (req_ready !== oh && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant", req_ready, oh);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("exec_no_rsp", rsp_valid, 2'b00);
    chk("alu_instruction", alu_instruction, v.op);
    chk("alu_operands", {alu_input1, alu_input2}, {v.a, v.b});
    @(negedge clk);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_flags", {rsp_zero, rsp_err}, {v.z, v.e});
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("rsp_done", rsp_valid, 2'b00);
  endtask

  initial begin
    int grants, resps, fgrants;
    logic [1:0] exp_grant;

    vecs[0] = '{1'b0, 3'd2, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd0, 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 3'd4, 8'h81, 8'h03, 8'h0C, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 3'd7, 8'h12, 8'h34, 8'hFF, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 3'd3, 8'hCC, 8'h0F, 8'h0C, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 3'd1, 8'h33, 8'h34, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 3'd5, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 3'd6, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err}, 0);
    chk("reset_alu", {alu_instruction, alu_input1, alu_input2}, 0);
    reset_n = 1'b1;

    // Round-robin with both ports continuously valid.
    @(negedge clk);
    req_op0 = 3'd2; req_a0 = 8'hF0; req_b0 = 8'h20;
    req_op1 = 3'd0; req_a1 = 8'h5A; req_b1 = 8'h5A;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    exp_grant = 2'b01;
    grants = 0;
    resps = 0;
    for (int cyc = 0; cyc < 60 && resps < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", req_ready, exp_grant);
        exp_grant = ~exp_grant;
        grants++;
      end
      if (rsp_valid == 2'b01) begin
        chk("rr_p0_result", {rsp_result, rsp_zero, rsp_err}, {8'h10, 1'b0, 1'b0});
        resps++;
      end else if (rsp_valid == 2'b10) begin
        chk("rr_p1_result", {rsp_result, rsp_zero, rsp_err}, {8'h00, 1'b1, 1'b0});
        resps++;
      end
      if (resps == 4) req_valid = 2'b00;
      @(negedge clk);
    end
    chk("rr_grant_count", grants, 4);
    chk("rr_resp_count", resps, 4);
    rsp_ready = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 10; i++) do_op(vecs[i]);

    // Backpressure on port 0 while port 1 waits.
    @(negedge clk);
    req_op0 = 3'd3; req_a0 = 8'hCC; req_b0 = 8'h0F;
    req_valid = 2'b01;
    #1;
    chk("bp_grant0", req_ready, 2'b01);
    @(posedge clk); #1;
    req_op1 = 3'd2; req_a1 = 8'h01; req_b1 = 8'h02;
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_exec_ready", req_ready, 2'b00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", rsp_valid, 2'b01);
      chk("bp_hold_result", {rsp_result, rsp_zero, rsp_err}, {8'h0C, 1'b0, 1'b0});
      chk("bp_hold_ready", req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    #1;
    chk("bp_handshake_ready", req_ready, 2'b00);
    chk("bp_handshake_valid", rsp_valid, 2'b01);
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("bp_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("bp_p1_result", {rsp_valid, rsp_result}, {2'b10, 8'h03});
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = 2'b00;

    // Reset during EXEC drops the operation.
    @(negedge clk);
    req_op0 = 3'd2; req_a0 = 8'hF0; req_b0 = 8'h20;
    req_op1 = 3'd0; req_a1 = 8'h5A; req_b1 = 8'h5A;
    req_valid = 2'b11;
    #1;
    chk("rst_pre_grant", req_ready, 2'b01);
    @(negedge clk);
    chk("rst_pre_exec", {rsp_valid, alu_instruction, rsp_result}, {2'b00, 3'd2, 8'h03});
    reset_n = 1'b0;
    #1;
    chk("rst_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err}, 0);
    chk("rst_alu", {alu_instruction, alu_input1, alu_input2}, 0);
    @(negedge clk);
    chk("rst_held_ready", {req_ready, rsp_valid}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst_exec_no_rsp", rsp_valid, 2'b00);
    @(negedge clk);
    chk("rst_new_rsp", {rsp_valid, rsp_result, rsp_zero}, {2'b01, 8'h10, 1'b0});
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    rsp_ready = 2'b00;

    // Fixed-priority instance: port 0 always wins.
    @(negedge clk);
    f_req_valid = 2'b11;
    f_rsp_ready = 2'b11;
    fgrants = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (f_req_ready != 2'b00) begin
        chk("fp_grant", f_req_ready, 2'b01);
        fgrants++;
      end
      if (f_rsp_valid != 2'b00) chk("fp_rsp", {f_rsp_valid, f_rsp_result}, {2'b01, 8'h10});
      @(negedge clk);
    end
    chk("fp_grant_count", fgrants >= 8, 1);
    f_req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
